// File: rtl/rec_df_pingpong_ram_if.sv
// Bundles the writer (reconstruction) and reader (deblocking filter) sides of the ping-pong RAM.
// master drives the strobes and addresses; slave is the RAM itself.
interface rec_df_pingpong_ram_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 7
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_done;
   logic              wr_ready;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_done;
   logic              rd_avail;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              addr_err;
   logic [1:0]        bank_full;

   modport master (
      output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
      input  wr_ready, rd_avail, rd_data, rd_valid, addr_err, bank_full
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
      output wr_ready, rd_avail, rd_data, rd_valid, addr_err, bank_full
   );
endinterface

// File: rtl/rec_df_pingpong_ram.sv
// Ping-pong RAM between reconstruction (writer) and deblocking filter (reader).
// Each bank is EMPTY or FULL; the writer only fills EMPTY banks and the reader only drains FULL ones.
module rec_df_pingpong_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 96,
   parameter int unsigned ADDR_W = 7
) (
   input logic                  clk,
   input logic                  reset_n,
   rec_df_pingpong_ram_if.slave bus
);
   localparam int unsigned IDX_W = ADDR_W + 1;

   typedef enum logic {BankEmpty, BankFull} bank_state_e;

   bank_state_e       bank_q [2];
   bank_state_e       bank_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              rd_valid_q, rd_valid_d;
   logic              addr_err_q, addr_err_d;
   logic [DATA_W-1:0] rd_data_q;

   // Both banks share one array; bank 1 occupies the upper DEPTH words.
   logic [DATA_W-1:0] mem [2*DEPTH];

   logic             wr_ready, rd_avail;
   logic             wr_in_range, rd_in_range;
   logic             wr_fire, wr_close, rd_fire, rd_release;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   assign wr_ready    = (bank_q[wr_ptr_q] == BankEmpty);
   assign rd_avail    = (bank_q[rd_ptr_q] == BankFull);
   assign wr_in_range = (32'(bus.wr_addr) < DEPTH);
   assign rd_in_range = (32'(bus.rd_addr) < DEPTH);

   assign wr_fire    = reset_n & bus.wr_en & wr_ready & wr_in_range;
   assign wr_close   = bus.wr_done & wr_ready;
   assign rd_fire    = bus.rd_en & rd_avail;
   assign rd_release = bus.rd_done & rd_avail;

   assign wr_idx = wr_ptr_q ? IDX_W'(DEPTH) + IDX_W'(bus.wr_addr) : IDX_W'(bus.wr_addr);
   assign rd_idx = rd_ptr_q ? IDX_W'(DEPTH) + IDX_W'(bus.rd_addr) : IDX_W'(bus.rd_addr);

   always_comb begin
      bank_d[0]  = bank_q[0];
      bank_d[1]  = bank_q[1];
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_valid_d = rd_fire;
      addr_err_d = addr_err_q;

      // Same-bank conflicts are impossible: wr_close needs EMPTY, rd_release needs FULL.
      if (wr_close) begin
         bank_d[wr_ptr_q] = BankFull;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (rd_release) begin
         bank_d[rd_ptr_q] = BankEmpty;
         rd_ptr_d         = ~rd_ptr_q;
      end

      if ((bus.wr_en & wr_ready & ~wr_in_range) | (rd_fire & ~rd_in_range)) begin
         addr_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bank_q[0]  <= BankEmpty;
         bank_q[1]  <= BankEmpty;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         bank_q[0]  <= bank_d[0];
         bank_q[1]  <= bank_d[1];
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
         addr_err_q <= addr_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_idx] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else if (rd_fire) begin
         rd_data_q <= rd_in_range ? mem[rd_idx] : '0;
      end
   end

   assign bus.wr_ready  = wr_ready;
   assign bus.rd_avail  = rd_avail;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.addr_err  = addr_err_q;
   assign bus.bank_full = {bank_q[1] == BankFull, bank_q[0] == BankFull};

   a_no_same_bank_handover: assert property (@(posedge clk) disable iff (!reset_n)
      !(wr_close && rd_release && (wr_ptr_q == rd_ptr_q)));

   a_ptrs_split_when_one_full: assert property (@(posedge clk) disable iff (!reset_n)
      ((bank_q[0] == BankFull) != (bank_q[1] == BankFull)) |-> (wr_ptr_q != rd_ptr_q));
endmodule

// File: tb/tb_rec_df_pingpong_ram.sv
// Bench for rec_df_pingpong_ram: directed vector table, hand sequences, then random traffic
// compared against a bank-count model of the ping-pong handover.
module tb_rec_df_pingpong_ram;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 96;
   localparam int unsigned ADDR_W = 7;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   rec_df_pingpong_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   rec_df_pingpong_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model state: which bank the writer owns and how many banks are full.
   // The reader's bank follows: it differs from the writer's only when exactly one is full.
   int          wbank;
   int          n_full;
   logic [31:0] mmem   [2][DEPTH];
   bit          mknown [2][DEPTH];
   logic [31:0] m_data;
   bit          m_known;
   bit          m_valid;
   bit          m_err;

   typedef struct {
      logic        rst_n;
      logic        wr_en;
      logic [6:0]  wr_addr;
      logic [31:0] wr_data;
      logic        wr_done;
      logic        rd_en;
      logic [6:0]  rd_addr;
      logic        rd_done;
      logic        e_ready;
      logic        e_avail;
      logic [1:0]  e_bf;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_err;
   } vec_t;

   vec_t vec [15];

   function automatic vec_t mk(logic rn, logic we, logic [6:0] wa, logic [31:0] wd, logic wdn,
                               logic re, logic [6:0] ra, logic rdn, logic er, logic ea,
                               logic [1:0] eb, logic ev, logic [31:0] ed, logic ee);
      vec_t v;
      v.rst_n = rn;  v.wr_en = we;  v.wr_addr = wa;  v.wr_data = wd; v.wr_done = wdn;
      v.rd_en = re;  v.rd_addr = ra; v.rd_done = rdn;
      v.e_ready = er; v.e_avail = ea; v.e_bf = eb; v.e_valid = ev; v.e_data = ed; v.e_err = ee;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rbank();
      return (n_full == 1) ? (wbank ^ 1) : wbank;
   endfunction

   function automatic logic [1:0] m_bank_full();
      if (n_full == 0) return 2'b00;
      if (n_full == 2) return 2'b11;
      return (rbank() == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic idle();
      reset_n     = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_done = 1'b0;
      bus.rd_en   = 1'b0;
      bus.rd_addr = '0;
      bus.rd_done = 1'b0;
   endtask

   // Advance the model with the inputs now on the bus, clock the DUT, then compare.
   task automatic tick();
      int  wa, ra, rb;
      bit  ready, avail, close, rel;
      if (!reset_n) begin
         n_full = 0; wbank = 0; m_valid = 0; m_data = '0; m_known = 1; m_err = 0;
      end else begin
         ready = (n_full < 2);
         avail = (n_full > 0);
         rb    = rbank();
         wa    = int'(bus.wr_addr);
         ra    = int'(bus.rd_addr);
         if (bus.wr_en && ready) begin
            if (wa < DEPTH) begin
               mmem[wbank][wa]   = bus.wr_data;
               mknown[wbank][wa] = 1;
            end else begin
               m_err = 1;
            end
         end
         m_valid = 0;
         if (bus.rd_en && avail) begin
            m_valid = 1;
            if (ra < DEPTH) begin
               m_data  = mmem[rb][ra];
               m_known = mknown[rb][ra];
            end else begin
               m_data  = '0;
               m_known = 1;
               m_err   = 1;
            end
         end
         close = bus.wr_done && ready;
         rel   = bus.rd_done && avail;
         if (close) begin
            n_full++;
            wbank ^= 1;
         end
         if (rel) n_full--;
      end
      @(posedge clk);
      #1;
      chk("m_wr_ready", 32'(bus.wr_ready), 32'(n_full < 2));
      chk("m_rd_avail", 32'(bus.rd_avail), 32'(n_full > 0));
      chk("m_bank_full", 32'(bus.bank_full), 32'(m_bank_full()));
      chk("m_rd_valid", 32'(bus.rd_valid), 32'(m_valid));
      chk("m_addr_err", 32'(bus.addr_err), 32'(m_err));
      if (m_known) chk("m_rd_data", bus.rd_data, m_data);
   endtask

   task automatic write_bank(logic [31:0] base);
      for (int a = 0; a < DEPTH; a++) begin
         idle();
         bus.wr_en   = 1'b1;
         bus.wr_addr = 7'(a);
         bus.wr_data = base + 32'(a);
         tick();
      end
      idle();
      bus.wr_done = 1'b1;
      tick();
   endtask

   task automatic read_word(int a);
      idle();
      bus.rd_en   = 1'b1;
      bus.rd_addr = 7'(a);
      tick();
   endtask

   initial begin
      // rst wen wa wd wdone ren ra rdone | ready avail bf valid data err
      vec[0]  = mk(0, 0, 0, 0,          0, 0, 0,   0, 1, 0, 2'b00, 0, 32'h0,    0);
      vec[1]  = mk(1, 0, 0, 0,          0, 0, 0,   0, 1, 0, 2'b00, 0, 32'h0,    0);
      vec[2]  = mk(1, 0, 0, 0,          0, 1, 0,   0, 1, 0, 2'b00, 0, 32'h0,    0);
      vec[3]  = mk(1, 1, 3, 32'h1111,   0, 0, 0,   0, 1, 0, 2'b00, 0, 32'h0,    0);
      vec[4]  = mk(1, 1, 4, 32'h2222,   1, 0, 0,   0, 1, 1, 2'b01, 0, 32'h0,    0);
      vec[5]  = mk(1, 0, 0, 0,          0, 1, 3,   0, 1, 1, 2'b01, 1, 32'h1111, 0);
      vec[6]  = mk(1, 1, 3, 32'h3333,   0, 1, 4,   0, 1, 1, 2'b01, 1, 32'h2222, 0);
      vec[7]  = mk(1, 0, 0, 0,          1, 0, 0,   0, 0, 1, 2'b11, 0, 32'h2222, 0);
      vec[8]  = mk(1, 1, 3, 32'hDEAD,   0, 1, 3,   0, 0, 1, 2'b11, 1, 32'h1111, 0);
      vec[9]  = mk(1, 0, 0, 0,          0, 1, 4,   1, 1, 1, 2'b10, 1, 32'h2222, 0);
      vec[10] = mk(1, 0, 0, 0,          0, 1, 3,   0, 1, 1, 2'b10, 1, 32'h3333, 0);
      vec[11] = mk(1, 0, 0, 0,          0, 1, 100, 0, 1, 1, 2'b10, 1, 32'h0,    1);
      vec[12] = mk(1, 1, 3, 32'h4444,   1, 0, 0,   1, 1, 1, 2'b01, 0, 32'h0,    1);
      vec[13] = mk(1, 0, 0, 0,          0, 1, 3,   0, 1, 1, 2'b01, 1, 32'h4444, 1);
      vec[14] = mk(0, 0, 0, 0,          0, 1, 3,   0, 1, 0, 2'b00, 0, 32'h0,    0);

      idle();
      for (int i = 0; i < 15; i++) begin
         reset_n     = vec[i].rst_n;
         bus.wr_en   = vec[i].wr_en;
         bus.wr_addr = vec[i].wr_addr;
         bus.wr_data = vec[i].wr_data;
         bus.wr_done = vec[i].wr_done;
         bus.rd_en   = vec[i].rd_en;
         bus.rd_addr = vec[i].rd_addr;
         bus.rd_done = vec[i].rd_done;
         tick();
         chk($sformatf("v%0d_wr_ready", i), 32'(bus.wr_ready), 32'(vec[i].e_ready));
         chk($sformatf("v%0d_rd_avail", i), 32'(bus.rd_avail), 32'(vec[i].e_avail));
         chk($sformatf("v%0d_bank_full", i), 32'(bus.bank_full), 32'(vec[i].e_bf));
         chk($sformatf("v%0d_rd_valid", i), 32'(bus.rd_valid), 32'(vec[i].e_valid));
         chk($sformatf("v%0d_rd_data", i), bus.rd_data, vec[i].e_data);
         chk($sformatf("v%0d_addr_err", i), 32'(bus.addr_err), 32'(vec[i].e_err));
      end

      // Full-bank fill, read, and dropped write into a full pair.
      idle();
      write_bank(32'hA000);
      chk("fill0_bank_full", 32'(bus.bank_full), 32'h1);
      read_word(5);
      chk("fill0_rd5", bus.rd_data, 32'hA005);
      write_bank(32'hB000);
      chk("both_full_ready", 32'(bus.wr_ready), 32'h0);
      idle();
      bus.wr_en = 1'b1; bus.wr_addr = 7'd0; bus.wr_data = 32'hDEAD;
      tick();
      read_word(0);
      chk("dropped_write_rd0", bus.rd_data, 32'hA000);

      // Simultaneous handover: bank0 full, bank1 being written.
      reset_n = 1'b0;
      tick();
      idle();
      write_bank(32'h5000);
      for (int a = 0; a < 8; a++) begin
         idle();
         bus.wr_en = 1'b1; bus.wr_addr = 7'(a); bus.wr_data = 32'h6000 + 32'(a);
         tick();
      end
      idle();
      bus.wr_done = 1'b1; bus.rd_done = 1'b1;
      tick();
      chk("swap_bank_full", 32'(bus.bank_full), 32'h2);
      chk("swap_wr_ready", 32'(bus.wr_ready), 32'h1);
      chk("swap_rd_avail", 32'(bus.rd_avail), 32'h1);
      read_word(2);
      chk("swap_reads_bank1", bus.rd_data, 32'h6002);

      // Out-of-range write must not alias into the other bank.
      idle();
      bus.wr_en = 1'b1; bus.wr_addr = 7'd96; bus.wr_data = 32'hBAD0;
      tick();
      chk("oor_wr_err", 32'(bus.addr_err), 32'h1);
      read_word(0);
      chk("oor_no_alias", bus.rd_data, 32'h6000);
      read_word(100);
      chk("oor_rd_zero", bus.rd_data, 32'h0);
      chk("oor_rd_valid", 32'(bus.rd_valid), 32'h1);
      idle();
      bus.rd_done = 1'b1;
      tick();
      idle();
      bus.wr_done = 1'b1;
      tick();
      for (int a = 0; a < DEPTH; a++) read_word(a);

      // Reset in the middle of reading a full bank, then a normal round trip.
      read_word(7);
      idle();
      reset_n = 1'b0; bus.rd_en = 1'b1; bus.rd_addr = 7'd9;
      tick();
      chk("rst_mid_valid", 32'(bus.rd_valid), 32'h0);
      chk("rst_mid_data", bus.rd_data, 32'h0);
      chk("rst_mid_bank_full", 32'(bus.bank_full), 32'h0);
      chk("rst_mid_ready", 32'(bus.wr_ready), 32'h1);
      idle();
      write_bank(32'hC000);
      read_word(95);
      chk("post_rst_rd95", bus.rd_data, 32'hC05F);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         reset_n     = ($urandom_range(0, 399) != 0);
         bus.wr_en   = ($urandom_range(0, 3) != 0);
         bus.wr_addr = ($urandom_range(0, 63) == 0) ? 7'($urandom_range(96, 127))
                                                    : 7'($urandom_range(0, 95));
         bus.wr_data = $urandom;
         bus.wr_done = ($urandom_range(0, 30) == 0);
         bus.rd_en   = ($urandom_range(0, 2) != 0);
         bus.rd_addr = ($urandom_range(0, 63) == 0) ? 7'($urandom_range(96, 127))
                                                    : 7'($urandom_range(0, 95));
         bus.rd_done = ($urandom_range(0, 30) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
